// File: rtl/tqvp_jnms_pdm_pkg.sv
// Shared widths, FSM encoding, saturation limits and configuration helpers
// for the PDM-to-PCM CIC decimator.
package tqvp_jnms_pdm_pkg;

    localparam int unsigned ORDER = 3;
    localparam int unsigned ACC_W = 25;
    localparam int unsigned PCM_W = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    localparam logic [7:0] R_MIN     = 8'd2;
    localparam logic [4:0] SHIFT_MAX = 5'd24;

    // Number of windows whose output is suppressed while the combs fill.
    localparam logic [1:0] SETTLE_WINDOWS = 2'd3;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    typedef struct packed {
        logic [7:0] decim;
        logic [4:0] shift;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{decim: R_MIN, shift: 5'd0};

    function automatic cfg_t cfg_clamp(input logic [7:0] decim, input logic [4:0] shift);
        cfg_t c;
        c.decim = (decim < R_MIN) ? R_MIN : decim;
        c.shift = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
        return c;
    endfunction

endpackage

// File: rtl/tqvp_jnms_pdm_cic_comb.sv
// Comb (differentiator) chain followed by the shift/saturate output stage.
// One register stage for the combs, one for the PCM output.
module tqvp_jnms_pdm_cic_comb
    import tqvp_jnms_pdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [ACC_W-1:0] in_data,
    input  logic             in_stb,
    input  logic             in_emit,
    input  logic [4:0]       shift,
    input  logic             clip_clr,
    output logic [PCM_W-1:0] pcm,
    output logic             pcm_valid,
    output logic             clip
);

    logic [ACC_W-1:0]        dly_q [ORDER];
    logic [ACC_W-1:0]        dly_d [ORDER];
    logic signed [ACC_W-1:0] c3_q, c3_d;
    logic                    emit_q, emit_d;
    logic [PCM_W-1:0]        pcm_q, pcm_d;
    logic                    pcm_valid_q, pcm_valid_d;
    logic                    clip_q, clip_d;

    logic [ACC_W-1:0]        diff;
    logic signed [ACC_W-1:0] shifted;
    logic                    sat_hi, sat_lo;

    always_comb begin
        dly_d  = dly_q;
        c3_d   = c3_q;
        emit_d = 1'b0;
        diff   = in_data;
        if (in_stb) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
                dly_d[k] = diff;
                diff     = diff - dly_q[k];
            end
            c3_d   = diff;
            emit_d = in_emit;
        end
        if (clr) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
                dly_d[k] = '0;
            end
            emit_d = 1'b0;
        end
    end

    always_comb begin
        shifted     = c3_q >>> shift;
        sat_hi      = (shifted > SAT_MAX);
        sat_lo      = (shifted < SAT_MIN);
        pcm_d       = pcm_q;
        pcm_valid_d = 1'b0;
        clip_d      = clip_q;
        if (clip_clr) begin
            clip_d = 1'b0;
        end
        // A disable squashes the sample already in the pipe; pcm keeps its value.
        if (emit_q && !clr) begin
            pcm_valid_d = 1'b1;
            if (sat_hi) begin
                pcm_d  = SAT_MAX[PCM_W-1:0];
                clip_d = 1'b1;
            end else if (sat_lo) begin
                pcm_d  = SAT_MIN[PCM_W-1:0];
                clip_d = 1'b1;
            end else begin
                pcm_d = shifted[PCM_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
                dly_q[k] <= '0;
            end
            c3_q        <= '0;
            emit_q      <= 1'b0;
            pcm_q       <= '0;
            pcm_valid_q <= 1'b0;
            clip_q      <= 1'b0;
        end else begin
            dly_q       <= dly_d;
            c3_q        <= c3_d;
            emit_q      <= emit_d;
            pcm_q       <= pcm_d;
            pcm_valid_q <= pcm_valid_d;
            clip_q      <= clip_d;
        end
    end

    assign pcm       = pcm_q;
    assign pcm_valid = pcm_valid_q;
    assign clip      = clip_q;

endmodule

// File: rtl/tqvp_jnms_pdm_cic.sv
// Third-order CIC decimator top: integrators, decimation counter,
// configuration latch and settle FSM feeding the comb/output stage.
module tqvp_jnms_pdm_cic
    import tqvp_jnms_pdm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  decim,
    input  logic [4:0]  shift,
    input  logic        pdm_data,
    input  logic        pdm_sample,
    input  logic        clip_clr,
    output logic [15:0] pcm,
    output logic        pcm_valid,
    output logic        clip
);

    logic [1:0]       state_q, state_d;
    cfg_t             cfg_q, cfg_d;
    logic [ACC_W-1:0] integ_q [ORDER];
    logic [ACC_W-1:0] integ_d [ORDER];
    logic [7:0]       cnt_q, cnt_d;
    logic [1:0]       settle_q, settle_d;
    logic             stb_q, stb_d;
    logic             emit_q, emit_d;

    logic             rise;
    logic [7:0]       r_eff;
    logic [ACC_W-1:0] acc;

    // IDLE means enable was low last cycle, so enable high here is the rising edge.
    assign rise  = enable && (state_q == ST_IDLE);
    assign r_eff = rise ? cfg_clamp(decim, shift).decim : cfg_q.decim;

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        integ_d  = integ_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        stb_d    = 1'b0;
        emit_d   = 1'b0;
        acc      = pdm_data ? ACC_W'(1) : '1;

        if (!enable) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            settle_d = '0;
            for (int unsigned k = 0; k < ORDER; k++) begin
                integ_d[k] = '0;
            end
        end else begin
            if (rise) begin
                cfg_d   = cfg_clamp(decim, shift);
                state_d = ST_SETTLE;
            end
            if (pdm_sample) begin
                for (int unsigned k = 0; k < ORDER; k++) begin
                    integ_d[k] = integ_q[k] + acc;
                    acc        = integ_d[k];
                end
                if (cnt_q == r_eff - 8'd1) begin
                    cnt_d = '0;
                    stb_d = 1'b1;
                    if (state_q == ST_RUN) begin
                        emit_d = 1'b1;
                    end else if (settle_q == SETTLE_WINDOWS - 2'd1) begin
                        settle_d = '0;
                        state_d  = ST_RUN;
                    end else begin
                        settle_d = settle_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cfg_q    <= CFG_RESET;
            for (int unsigned k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
            end
            cnt_q    <= '0;
            settle_q <= '0;
            stb_q    <= 1'b0;
            emit_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            integ_q  <= integ_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            stb_q    <= stb_d;
            emit_q   <= emit_d;
        end
    end

    tqvp_jnms_pdm_cic_comb u_comb (
        .clk       (clk),
        .rst       (rst),
        .clr       (!enable),
        .in_data   (integ_q[ORDER-1]),
        .in_stb    (stb_q),
        .in_emit   (emit_q),
        .shift     (cfg_q.shift),
        .clip_clr  (clip_clr),
        .pcm       (pcm),
        .pcm_valid (pcm_valid),
        .clip      (clip)
    );

endmodule
